// File: rtl/sand_mem_arbiter.sv
// Single-port cell RAM arbiter: scanout reads win, the sim engine takes leftover cycles.
// Also launches one sim step per frame at vblank and counts steps that overrun a frame.
module sand_mem_arbiter #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vblank_start,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              sim_req,
   input  logic              sim_we,
   input  logic [ADDR_W-1:0] sim_addr,
   input  logic [DATA_W-1:0] sim_wdata,
   output logic              sim_gnt,
   output logic              sim_rvalid,
   output logic [DATA_W-1:0] sim_rdata,
   output logic              sim_start,
   input  logic              sim_done,
   output logic              sim_busy,
   output logic              sim_starved,
   output logic [7:0]        overrun_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, START, RUN} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   last_addr;
   logic [1:0]          tag_p0;
   logic [1:0]          tag_p [RD_LAT];
   logic [WAIT_W-1:0]   wait_cnt;
   logic                wait_inc;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
      return (v == WAIT_W'(MAX_WAIT)) ? v : v + 1'b1;
   endfunction

   assign sim_start = (state == START);
   assign sim_busy  = (state == RUN);

   // Arbitration: tag {disp,sim} marks which requester owns a pending read
   always_comb begin
      disp_gnt  = 1'b0;
      sim_gnt   = 1'b0;
      mem_addr  = last_addr;
      mem_we    = 1'b0;
      mem_wdata = '0;
      tag_p0    = 2'b00;
      if (disp_req) begin
         disp_gnt = 1'b1;
         mem_addr = disp_addr;
         tag_p0   = 2'b10;
      end else if (sim_req && sim_busy) begin
         sim_gnt   = 1'b1;
         mem_addr  = sim_addr;
         mem_we    = sim_we;
         mem_wdata = sim_wdata;
         tag_p0    = {1'b0, !sim_we};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_addr <= '0;
      else if (disp_gnt || sim_gnt) last_addr <= mem_addr;
   end

   // Read-tag pipeline: stage RD_LAT-1 lines up with mem_rdata
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) tag_p[i] <= 2'b00;
      end else begin
         tag_p[0] <= tag_p0;
         for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   assign disp_rvalid = tag_p[RD_LAT-1][1];
   assign sim_rvalid  = tag_p[RD_LAT-1][0];
   assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
   assign sim_rdata   = sim_rvalid  ? mem_rdata : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (vblank_start) state_nxt = START;
         START:   state_nxt = RUN;
         RUN:     if (sim_done) state_nxt = vblank_start ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         overrun_count <= 8'd0;
      end else begin
         state <= state_nxt;
         if (sim_busy && vblank_start && !sim_done)
            overrun_count <= sat_inc8(overrun_count);
      end
   end

   // Starvation: only counts cycles where the sim could have been served
   assign wait_inc = sim_req && sim_busy && !sim_gnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= '0;
         sim_starved <= 1'b0;
      end else begin
         if (!sim_req || sim_gnt) wait_cnt <= '0;
         else if (wait_inc)       wait_cnt <= sat_inc_wait(wait_cnt);
         if (wait_inc && wait_cnt == WAIT_W'(MAX_WAIT - 1)) sim_starved <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sand_mem_arbiter.sv
// Directed bench for sand_mem_arbiter with a 1-cycle-latency RAM model.
// Unwritten RAM cells read back as addr[7:0] ^ 8'h79 (so 0x0123 holds 0x5A).
module tb_sand_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        vblank_start, disp_req, sim_req, sim_we, sim_done;
   logic [14:0] disp_addr, sim_addr, mem_addr;
   logic [7:0]  sim_wdata, disp_rdata, sim_rdata, mem_wdata, mem_rdata, overrun_count;
   logic        disp_gnt, disp_rvalid, sim_gnt, sim_rvalid, sim_start, sim_busy, sim_starved, mem_we;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] ram     [0:32767];
   bit         written [0:32767];
   logic [7:0] disp_exp [0:2];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? ram[mem_addr] : (mem_addr[7:0] ^ 8'h79);
   end

   sand_mem_arbiter dut (
      .clk(clk), .reset(reset), .vblank_start(vblank_start),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .sim_req(sim_req), .sim_we(sim_we), .sim_addr(sim_addr), .sim_wdata(sim_wdata),
      .sim_gnt(sim_gnt), .sim_rvalid(sim_rvalid), .sim_rdata(sim_rdata),
      .sim_start(sim_start), .sim_done(sim_done), .sim_busy(sim_busy),
      .sim_starved(sim_starved), .overrun_count(overrun_count),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      disp_exp[0] = 8'h79; disp_exp[1] = 8'h78; disp_exp[2] = 8'h7B;
      reset = 1'b1; vblank_start = 0; disp_req = 0; sim_req = 0; sim_we = 0; sim_done = 0;
      disp_addr = '0; sim_addr = '0; sim_wdata = '0;
      repeat (2) adv();
      @(negedge clk);
      chk("rst_start", sim_start, 0);
      chk("rst_busy", sim_busy, 0);
      chk("rst_starved", sim_starved, 0);
      chk("rst_overrun", overrun_count, 0);
      chk("rst_rvalids", {disp_rvalid, sim_rvalid}, 0);
      chk("rst_gnts", {disp_gnt, sim_gnt}, 0);
      chk("rst_mem", {mem_addr, mem_we}, 0);
      adv();
      reset = 1'b0;

      // sim request outside a step is never granted
      sim_req = 1; sim_addr = 15'h0123;
      @(negedge clk); chk("idle_sim_gnt", sim_gnt, 0);
      adv(); sim_req = 0;

      // vblank -> START for one cycle -> RUN
      vblank_start = 1;
      @(negedge clk); chk("t1_start_pre", sim_start, 0);
      adv(); vblank_start = 0;
      @(negedge clk); chk("t1_start", sim_start, 1); chk("t1_busy_pre", sim_busy, 0);
      adv();
      @(negedge clk); chk("t1_start_end", sim_start, 0); chk("t1_busy", sim_busy, 1);
      adv();

      // lone sim read
      sim_req = 1; sim_we = 0; sim_addr = 15'h0123;
      @(negedge clk);
      chk("t2_gnt", sim_gnt, 1); chk("t2_addr", mem_addr, 15'h0123); chk("t2_we", mem_we, 0);
      adv(); sim_req = 0;
      @(negedge clk);
      chk("t2_rvalid", sim_rvalid, 1); chk("t2_rdata", sim_rdata, 8'h5A);
      chk("t2_disp_rvalid", disp_rvalid, 0); chk("t2_addr_hold", mem_addr, 15'h0123);
      adv();
      @(negedge clk); chk("t2_rvalid_end", sim_rvalid, 0);
      adv();

      // sim write produces no rvalid
      sim_req = 1; sim_we = 1; sim_addr = 15'h0300; sim_wdata = 8'hC3;
      @(negedge clk);
      chk("wr_gnt", sim_gnt, 1); chk("wr_we", mem_we, 1);
      chk("wr_wdata", mem_wdata, 8'hC3); chk("wr_addr", mem_addr, 15'h0300);
      adv(); sim_req = 0; sim_we = 0;
      @(negedge clk); chk("wr_no_rvalid", sim_rvalid, 0); chk("wr_we_idle", mem_we, 0);
      adv();

      // display priority, then sim, rvalids in grant order
      sim_req = 1; sim_addr = 15'h0300;
      for (int i = 0; i < 3; i++) begin
         disp_req = 1; disp_addr = 15'h0200 + 15'(i);
         @(negedge clk);
         chk("t3_disp_gnt", disp_gnt, 1); chk("t3_sim_gnt", sim_gnt, 0);
         chk("t3_addr", mem_addr, 15'h0200 + 15'(i));
         if (i > 0) begin
            chk("t3_disp_rvalid", disp_rvalid, 1);
            chk("t3_disp_rdata", disp_rdata, disp_exp[i-1]);
         end
         adv();
      end
      disp_req = 0;
      @(negedge clk);
      chk("t3_sim_gnt4", sim_gnt, 1); chk("t3_addr4", mem_addr, 15'h0300);
      chk("t3_disp_rvalid3", disp_rvalid, 1); chk("t3_disp_rdata3", disp_rdata, 8'h7B);
      chk("t3_sim_rvalid_early", sim_rvalid, 0);
      adv(); sim_req = 0;
      @(negedge clk);
      chk("t3_sim_rvalid", sim_rvalid, 1); chk("t3_sim_rdata", sim_rdata, 8'hC3);
      chk("t3_disp_rvalid_end", disp_rvalid, 0);
      adv();

      // starvation after 64 ungranted cycles
      sim_req = 1; sim_addr = 15'h0123; disp_req = 1; disp_addr = 15'h0100;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (i == 0 || i == 63) chk("t4_sim_gnt", sim_gnt, 0);
         if (i == 62) chk("t4_not_starved", sim_starved, 0);
         adv();
      end
      disp_req = 0;
      @(negedge clk); chk("t4_starved", sim_starved, 1); chk("t4_gnt_after", sim_gnt, 1);
      adv(); sim_req = 0;
      @(negedge clk); chk("t4_rdata", sim_rdata, 8'h5A);
      repeat (3) adv();
      @(negedge clk); chk("t4_sticky", sim_starved, 1);
      adv();

      // overruns: three vblanks without sim_done
      for (int k = 0; k < 3; k++) begin
         vblank_start = 1; adv(); vblank_start = 0;
         @(negedge clk); chk("t5_no_start", sim_start, 0); chk("t5_busy", sim_busy, 1);
         adv();
      end
      @(negedge clk); chk("t5_overrun3", overrun_count, 3);
      vblank_start = 1; sim_done = 1; adv(); vblank_start = 0; sim_done = 0;
      @(negedge clk); chk("t5_restart", sim_start, 1); chk("t5_overrun_keep", overrun_count, 3);
      adv();
      @(negedge clk); chk("t5_busy_again", sim_busy, 1);
      adv();

      // step completion, then sim_done ignored while idle
      sim_done = 1; adv(); sim_done = 0;
      @(negedge clk); chk("done_idle", {sim_busy, sim_start}, 0);
      adv();
      sim_done = 1; adv(); sim_done = 0;
      @(negedge clk); chk("done_ignored", {sim_busy, sim_start}, 0);
      adv();

      // overrun counter saturates at 255
      vblank_start = 1; adv(); vblank_start = 0; adv();
      @(negedge clk); chk("sat_busy", sim_busy, 1);
      adv();
      for (int k = 0; k < 260; k++) begin
         vblank_start = 1; adv(); vblank_start = 0; adv();
      end
      @(negedge clk); chk("sat_overrun", overrun_count, 8'hFF); chk("sat_no_start", sim_start, 0);
      adv();

      // reset with a read in flight and the FSM in RUN
      sim_req = 1; sim_we = 0; sim_addr = 15'h0123;
      @(negedge clk); chk("t6_gnt", sim_gnt, 1);
      #1 reset = 1'b1; sim_req = 0;
      adv();
      @(negedge clk);
      chk("t6_rvalid", sim_rvalid, 0); chk("t6_busy", sim_busy, 0);
      chk("t6_overrun", overrun_count, 0); chk("t6_starved", sim_starved, 0);
      adv(); reset = 1'b0;
      @(negedge clk); chk("t6_rvalid_post", {disp_rvalid, sim_rvalid}, 0);
      adv();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
